// File: rtl/decode_stage.sv
// Registered decode stage: splits instr into typed fields,
// valid/ready on both sides, flush, illegal-opcode counter.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   in_valid/in_ready  upstream handshake, instr = raw word
//   flush              drop held and incoming instructions
//   out_valid/out_ready downstream handshake
//   opcode_o type_o rde_o rs1_o rs2_o func_o imm_o illegal_o
//                      decoded fields (imm sign-extended)
//   ill_cnt_o          saturating count of accepted illegals
//
// Macro DECODE_SKID_EN: adds a one-entry skid buffer so that
// in_ready is registered (no out_ready->in_ready path).
// Type codes: E=0 R=1 M=2 I=3 F=4 B=5 U=6.

`ifndef ORR
`define ORR 8'h10
`endif
`ifndef ORI
`define ORI 8'h11
`endif

module decode_stage #(
  parameter int DATA_W    = 32,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           opcode_o,
  output logic [2:0]           type_o,
  output logic [3:0]           rde_o,
  output logic [3:0]           rs1_o,
  output logic [3:0]           rs2_o,
  output logic [3:0]           func_o,
  output logic [DATA_W-1:0]    imm_o,
  output logic                 illegal_o,
  output logic [ILL_CNT_W-1:0] ill_cnt_o
);

  localparam logic [2:0] T_E = 3'd0;
  localparam logic [2:0] T_R = 3'd1;
  localparam logic [2:0] T_M = 3'd2;
  localparam logic [2:0] T_I = 3'd3;
  localparam logic [2:0] T_F = 3'd4;
  localparam logic [2:0] T_B = 3'd5;
  localparam logic [2:0] T_U = 3'd6;

  typedef struct packed {
    logic [7:0]        op;
    logic [2:0]        ty;
    logic [3:0]        rde;
    logic [3:0]        rs1;
    logic [3:0]        rs2;
    logic [3:0]        func;
    logic [DATA_W-1:0] imm;
    logic              ill;
  } dec_t;

  dec_t dec;
  logic [2:0] ty;
  logic       ill;

  always_comb begin
    ty  = T_E;
    ill = 1'b0;
    unique case (1'b1)
      (instr[7:0] == `ORR): ty = T_R;
      (instr[7:0] == `ORI): ty = T_I;
      default:              ill = 1'b1;
    endcase
  end

  // M/F/B/U have no opcodes in the table yet; their field
  // layouts are kept so new opcodes only need a table entry.
  always_comb begin
    dec     = '0;
    dec.op  = instr[7:0];
    dec.ty  = ty;
    dec.ill = ill;
    unique case (ty)
      T_R: begin
        dec.imm = DATA_W'($signed(instr[19:8]));
        dec.rs2 = instr[23:20];
        dec.rs1 = instr[27:24];
        dec.rde = instr[31:28];
      end
      T_M: begin
        dec.imm  = DATA_W'($signed(instr[19:8]));
        dec.func = instr[23:20];
        dec.rs1  = instr[27:24];
        dec.rde  = instr[31:28];
      end
      T_I: begin
        dec.imm = DATA_W'($signed(instr[23:8]));
        dec.rs1 = instr[27:24];
        dec.rde = instr[31:28];
      end
      T_F: begin
        dec.imm  = DATA_W'($signed(instr[23:8]));
        dec.func = instr[27:24];
        dec.rde  = instr[31:28];
      end
      T_B: begin
        dec.imm  = DATA_W'($signed(instr[27:8]));
        dec.func = instr[31:28];
      end
      T_U: begin
        dec.imm = DATA_W'($signed(instr[31:8]));
      end
      default: begin
        // illegal: every field stays zero
      end
    endcase
  end

  dec_t                 out_q, out_d;
  logic                 ov_q, ov_d;
  logic [ILL_CNT_W-1:0] cnt_q, cnt_d;
  logic                 accept;

  assign accept = in_valid & in_ready;

`ifdef DECODE_SKID_EN
  dec_t skid_q, skid_d;
  logic sv_q, sv_d;

  assign in_ready = ~sv_q;

  always_comb begin
    out_d  = out_q;
    ov_d   = ov_q;
    skid_d = skid_q;
    sv_d   = sv_q;
    cnt_d  = cnt_q;
    if (flush) begin
      ov_d = 1'b0;
      sv_d = 1'b0;
    end else begin
      if (accept & dec.ill & ~&cnt_q)
        cnt_d = cnt_q + ILL_CNT_W'(1);
      if (~ov_q | out_ready) begin
        // in_ready is low while skid is full, so no
        // accept can collide with the skid move.
        if (sv_q) begin
          out_d = skid_q;
          ov_d  = 1'b1;
          sv_d  = 1'b0;
        end else if (accept) begin
          out_d = dec;
          ov_d  = 1'b1;
        end else begin
          ov_d = 1'b0;
        end
      end else if (accept) begin
        skid_d = dec;
        sv_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q <= '0;
      sv_q   <= 1'b0;
    end else begin
      skid_q <= skid_d;
      sv_q   <= sv_d;
    end
  end
`else
  assign in_ready = ~ov_q | out_ready;

  always_comb begin
    out_d = out_q;
    ov_d  = ov_q;
    cnt_d = cnt_q;
    if (flush) begin
      ov_d = 1'b0;
    end else begin
      if (accept & dec.ill & ~&cnt_q)
        cnt_d = cnt_q + ILL_CNT_W'(1);
      if (accept) begin
        out_d = dec;
        ov_d  = 1'b1;
      end else if (out_ready) begin
        ov_d = 1'b0;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      ov_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      out_q <= out_d;
      ov_q  <= ov_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = ov_q;
  assign opcode_o  = out_q.op;
  assign type_o    = out_q.ty;
  assign rde_o     = out_q.rde;
  assign rs1_o     = out_q.rs1;
  assign rs2_o     = out_q.rs2;
  assign func_o    = out_q.func;
  assign imm_o     = out_q.imm;
  assign illegal_o = out_q.ill;
  assign ill_cnt_o = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: vector table, queue scoreboard,
// backpressure, flush, saturation and reset sequences.

`ifndef ORR
`define ORR 8'h10
`endif
`ifndef ORI
`define ORI 8'h11
`endif

module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  opcode_o;
  logic [2:0]  type_o;
  logic [3:0]  rde_o, rs1_o, rs2_o, func_o;
  logic [31:0] imm_o;
  logic        illegal_o;
  logic [7:0]  ill_cnt_o;

  decode_stage #(.DATA_W(32), .ILL_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode_o(opcode_o), .type_o(type_o),
    .rde_o(rde_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .func_o(func_o), .imm_o(imm_o),
    .illegal_o(illegal_o), .ill_cnt_o(ill_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  op;
    logic [2:0]  ty;
    logic [3:0]  rde;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  func;
    logic [31:0] imm;
    logic        ill;
  } dec_t;

  typedef struct {
    logic [31:0] ins;
    dec_t        exp;
  } vec_t;

  int checks = 0;
  int failures = 0;
  dec_t q[$];
  logic [7:0] cnt_m = '0;

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, a, e);
    end
  endtask

  function automatic dec_t act();
    dec_t d;
    d.op = opcode_o; d.ty = type_o; d.rde = rde_o;
    d.rs1 = rs1_o; d.rs2 = rs2_o; d.func = func_o;
    d.imm = imm_o; d.ill = illegal_o;
    return d;
  endfunction

  function automatic logic [31:0] sx(longint v, int b);
    if (v >= (longint'(1) << (b - 1)))
      return 32'(v - (longint'(1) << b));
    return 32'(v);
  endfunction

  function automatic dec_t exp_dec(logic [31:0] ins);
    dec_t d;
    longint w;
    w = longint'(ins);
    d = '0;
    d.op = ins[7:0];
    if (ins[7:0] == `ORR) begin
      d.ty  = 3'd1;
      d.rde = 4'((w >> 28) & 15);
      d.rs1 = 4'((w >> 24) & 15);
      d.rs2 = 4'((w >> 20) & 15);
      d.imm = sx((w >> 8) & 'hFFF, 12);
    end else if (ins[7:0] == `ORI) begin
      d.ty  = 3'd3;
      d.rde = 4'((w >> 28) & 15);
      d.rs1 = 4'((w >> 24) & 15);
      d.imm = sx((w >> 8) & 'hFFFF, 16);
    end else begin
      d.ill = 1'b1;
    end
    return d;
  endfunction

  function automatic logic exp_ready(logic r);
`ifdef DECODE_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || r;
`endif
  endfunction

  task automatic cycle(input logic v, input logic [31:0] ins,
                       input logic r, input logic f,
                       output logic acc);
    logic er, pop, push;
    dec_t d;
    in_valid = v; instr = ins; out_ready = r; flush = f;
    #1;
    er = exp_ready(r);
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(er));
    chk("ill_cnt", 64'(ill_cnt_o), 64'(cnt_m));
    if (q.size() > 0) chk("fields", 64'(act()), 64'(q[0]));
    pop  = (q.size() > 0) && r;
    push = v && er;
    acc  = push && !f;
    @(posedge clk);
    #1;
    if (f) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        d = exp_dec(ins);
        q.push_back(d);
        if (d.ill && cnt_m != 8'hFF) cnt_m++;
      end
    end
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 3))
      0: w[7:0] = `ORR;
      1: w[7:0] = `ORI;
      default: ;
    endcase
    return w;
  endfunction

  task automatic drain();
    logic a;
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0, a);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    logic acc;
    logic [31:0] sendq[$];
    logic [31:0] sent[$];
    dec_t recv[$];
    logic [7:0] csave;

    tbl[0] = '{{4'h3, 4'h5, 16'h8001, `ORI},
               '{`ORI, 3'd3, 4'h3, 4'h5, 4'h0, 4'h0,
                 32'hFFFF8001, 1'b0}};
    tbl[1] = '{{4'hA, 4'h2, 4'h7, 12'h07F, `ORR},
               '{`ORR, 3'd1, 4'hA, 4'h2, 4'h7, 4'h0,
                 32'h0000007F, 1'b0}};
    tbl[2] = '{{4'h1, 4'hF, 4'h0, 12'h800, `ORR},
               '{`ORR, 3'd1, 4'h1, 4'hF, 4'h0, 4'h0,
                 32'hFFFFF800, 1'b0}};
    tbl[3] = '{{4'hF, 4'h0, 16'h7FFF, `ORI},
               '{`ORI, 3'd3, 4'hF, 4'h0, 4'h0, 4'h0,
                 32'h00007FFF, 1'b0}};
    tbl[4] = '{{24'hFFFFFF, 8'hFF},
               '{8'hFF, 3'd0, 4'h0, 4'h0, 4'h0, 4'h0,
                 32'h0, 1'b1}};
    tbl[5] = '{{24'h123456, 8'h00},
               '{8'h00, 3'd0, 4'h0, 4'h0, 4'h0, 4'h0,
                 32'h0, 1'b1}};

    // reset held 3 clocks with traffic offered
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1; out_ready = 1'b1;
      instr = {24'h0, `ORI};
      #1;
      chk("rst_valid", 64'(out_valid), 64'(0));
      chk("rst_cnt", 64'(ill_cnt_o), 64'(0));
      chk("rst_fields", 64'(act()), 64'(0));
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;

    // directed vectors, out_ready high
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, tbl[i].ins, 1'b1, 1'b0, acc);
      chk($sformatf("vec%0d_acc", i), 64'(acc), 64'(1));
      chk($sformatf("vec%0d_valid", i),
          64'(out_valid), 64'(1));
      chk($sformatf("vec%0d_fields", i),
          64'(act()), 64'(tbl[i].exp));
    end
    drain();

    // backpressure: 4 back-to-back, out_ready low 3 cycles
    for (int i = 0; i < 4; i++)
      sendq.push_back({4'(i), 4'(i + 1), 16'h8000 + 16'(i),
                       (i % 2) ? `ORR : `ORI});
    for (int k = 0; k < 20; k++) begin
      logic r, v;
      r = (k >= 3);
      v = sendq.size() > 0;
      if (out_valid && r) recv.push_back(act());
      cycle(v, v ? sendq[0] : 32'h0, r, 1'b0, acc);
      if (acc) sent.push_back(sendq.pop_front());
    end
    chk("bp_count", 64'(recv.size()), 64'(4));
    for (int i = 0; i < recv.size() && i < sent.size(); i++)
      chk($sformatf("bp_order%0d", i),
          64'(recv[i]), 64'(exp_dec(sent[i])));

    // flush while stalled with incoming illegal
    drain();
    cycle(1'b1, {4'h3, 4'h5, 16'h1234, `ORI}, 1'b0, 1'b0, acc);
    cycle(1'b1, {4'h6, 4'h7, 4'h8, 12'h9, `ORR},
          1'b0, 1'b0, acc);
    csave = cnt_m;
    cycle(1'b1, {24'h0, 8'hFF}, 1'b0, 1'b1, acc);
    chk("flush_valid", 64'(out_valid), 64'(0));
    chk("flush_cnt", 64'(ill_cnt_o), 64'(csave));
    chk("flush_ready", 64'(in_ready), 64'(1));
    cycle(1'b0, '0, 1'b1, 1'b0, acc);

    // randomized traffic against the queue model
    for (int k = 0; k < 2000; k++)
      cycle($urandom_range(0, 3) != 0, rnd_instr(),
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0, acc);

    // illegal counter saturation
    drain();
    for (int k = 0; k < 300; k++)
      cycle(1'b1, {$urandom_range(0, 255) == 0 ?
                   24'h0 : 24'(k), 8'hFF}, 1'b1, 1'b0, acc);
    chk("sat_cnt", 64'(ill_cnt_o), 64'(8'hFF));
    chk("sat_ill", 64'(illegal_o), 64'(1));
    chk("sat_type", 64'(type_o), 64'(0));

    // reset asserted with an instruction held
    cycle(1'b1, {4'h9, 4'h9, 16'hFFFF, `ORI}, 1'b0, 1'b0, acc);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 64'(out_valid), 64'(0));
    chk("mrst_fields", 64'(act()), 64'(0));
    chk("mrst_cnt", 64'(ill_cnt_o), 64'(0));
    q.delete();
    cnt_m = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b0, '0, 1'b1, 1'b0, acc);
    cycle(1'b1, tbl[1].ins, 1'b1, 1'b0, acc);
    chk("post_rst", 64'(act()), 64'(tbl[1].exp));

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
